tuner_phy_ctrl_arb: RTL and testbench

- Shares the single ring-tuner DAC and power-detect path between the search controller (CH_SEARCH) and the lock controller (CH_LOCK).
- Each granted transaction runs TUNE (apply the code and let it settle), then SYNC (handshake one power sample), then COMMIT (return the sample to the owner).
- States use tuner_phy_ctrl_arb_state_e; channel encoding uses tuner_ctrl_ch_e from tuner_phy_pkg.
- Sits between the two controllers and the tuner DAC / power-detect front end.

---
 rtl/tuner_phy_ctrl_arb.sv | 154 +++++++++++++++
 tb/tb_tuner_phy_ctrl_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tuner_phy_ctrl_arb.sv
// Arbitrates the shared ring-tuner DAC and power-detect path between the
// search and lock controllers; each grant runs TUNE -> SYNC -> COMMIT.

package tuner_phy_pkg;
    typedef enum logic [1:0] {
        CH_NULL   = 2'd0,
        CH_SEARCH = 2'd1,
        CH_LOCK   = 2'd2
    } tuner_ctrl_ch_e;

    typedef enum logic [1:0] {
        ARB_CTRL_INIT   = 2'd0,
        ARB_CTRL_TUNE   = 2'd1,
        ARB_CTRL_SYNC   = 2'd2,
        ARB_CTRL_COMMIT = 2'd3
    } tuner_phy_ctrl_arb_state_e;
endpackage

module tuner_phy_ctrl_arb
    import tuner_phy_pkg::*;
#(
    parameter int DAC_WIDTH      = 8,
    parameter int PWR_WIDTH      = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 search_req,
    input  logic [DAC_WIDTH-1:0] search_code,
    output logic                 search_gnt,
    output logic                 search_pwr_valid,
    input  logic                 lock_req,
    input  logic [DAC_WIDTH-1:0] lock_code,
    output logic                 lock_gnt,
    output logic                 lock_pwr_valid,
    output logic [PWR_WIDTH-1:0] pwr_out,
    output logic [DAC_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 pdet_req,
    input  logic                 pdet_ack,
    input  logic [PWR_WIDTH-1:0] pdet_pwr,
    output logic [1:0]           ch_sel,
    output logic [1:0]           arb_state,
    output logic                 err_timeout
);
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    tuner_phy_ctrl_arb_state_e state_q, state_d;
    tuner_ctrl_ch_e            owner_q, owner_d;
    tuner_ctrl_ch_e            last_q, last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0]      dac_code_q, dac_code_d;
    logic [PWR_WIDTH-1:0]      pwr_q, pwr_d;
    logic                      err_q, err_d;
    logic                      tune_first;

    // NOTE: every output of this block is assigned a default before the case,
    // so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        dac_code_d = dac_code_q;
        pwr_d      = pwr_q;
        err_d      = 1'b0;
        case (state_q)
            ARB_CTRL_INIT: begin
                // On a tie the channel not served last wins.
                if (search_req && (!lock_req || last_q == CH_LOCK)) begin
                    owner_d    = CH_SEARCH;
                    dac_code_d = search_code;
                    cnt_d      = '0;
                    state_d    = ARB_CTRL_TUNE;
                end else if (lock_req) begin
                    owner_d    = CH_LOCK;
                    dac_code_d = lock_code;
                    cnt_d      = '0;
                    state_d    = ARB_CTRL_TUNE;
                end
            end
            ARB_CTRL_TUNE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ARB_CTRL_SYNC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_CTRL_SYNC: begin
                if (pdet_ack) begin
                    pwr_d   = pdet_pwr;
                    state_d = ARB_CTRL_COMMIT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    owner_d = CH_NULL;
                    state_d = ARB_CTRL_INIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                last_d  = owner_q;
                owner_d = CH_NULL;
                state_d = ARB_CTRL_INIT;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; the async reset puts the outputs at idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_CTRL_INIT;
            owner_q    <= CH_NULL;
            last_q     <= CH_LOCK;
            cnt_q      <= '0;
            dac_code_q <= '0;
            pwr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            dac_code_q <= dac_code_d;
            pwr_q      <= pwr_d;
            err_q      <= err_d;
        end
    end

    assign tune_first       = (state_q == ARB_CTRL_TUNE) && (cnt_q == '0);
    assign search_gnt       = tune_first && (owner_q == CH_SEARCH);
    assign lock_gnt         = tune_first && (owner_q == CH_LOCK);
    assign dac_load         = tune_first;
    assign pdet_req         = (state_q == ARB_CTRL_SYNC);
    assign search_pwr_valid = (state_q == ARB_CTRL_COMMIT) && (owner_q == CH_SEARCH);
    assign lock_pwr_valid   = (state_q == ARB_CTRL_COMMIT) && (owner_q == CH_LOCK);
    assign pwr_out          = pwr_q;
    assign dac_code         = dac_code_q;
    assign ch_sel           = owner_q;
    assign arb_state        = state_q;
    assign err_timeout      = err_q;

    a_gnt_first_tune: assert property (@(posedge clk) disable iff (rst)
        (search_gnt || lock_gnt) |-> tune_first);
    a_pdet_sync: assert property (@(posedge clk) disable iff (rst)
        pdet_req |-> (state_q == ARB_CTRL_SYNC));
    a_null_init: assert property (@(posedge clk) disable iff (rst)
        (owner_q == CH_NULL) == (state_q == ARB_CTRL_INIT));
endmodule

// File: tb/tb_tuner_phy_ctrl_arb.sv
// Self-checking bench for tuner_phy_ctrl_arb: vector table for single
// transactions plus hand sequences for round-robin, timeout, reset, ack noise.
module tb_tuner_phy_ctrl_arb;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam logic [1:0] S_INIT = 2'd0, S_TUNE = 2'd1, S_SYNC = 2'd2, S_COMMIT = 2'd3;
    localparam logic [1:0] C_NULL = 2'd0, C_SEARCH = 2'd1, C_LOCK = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       search_req, lock_req, pdet_ack;
    logic [7:0] search_code, lock_code, pdet_pwr;
    logic       search_gnt, search_pwr_valid, lock_gnt, lock_pwr_valid;
    logic       dac_load, pdet_req, err_timeout;
    logic [7:0] pwr_out, dac_code;
    logic [1:0] ch_sel, arb_state;

    tuner_phy_ctrl_arb #(
        .DAC_WIDTH(8), .PWR_WIDTH(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .search_req(search_req), .search_code(search_code),
        .search_gnt(search_gnt), .search_pwr_valid(search_pwr_valid),
        .lock_req(lock_req), .lock_code(lock_code),
        .lock_gnt(lock_gnt), .lock_pwr_valid(lock_pwr_valid),
        .pwr_out(pwr_out), .dac_code(dac_code), .dac_load(dac_load),
        .pdet_req(pdet_req), .pdet_ack(pdet_ack), .pdet_pwr(pdet_pwr),
        .ch_sel(ch_sel), .arb_state(arb_state), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        logic       s_req;
        logic       l_req;
        logic [7:0] s_code;
        logic [7:0] l_code;
        int         ack_dly;
        logic [7:0] pwr;
        logic [1:0] exp_ch;
        logic [7:0] exp_code;
    } vec_t;

    exp_t gnt_q[$];
    exp_t val_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_gnt = 0;
    int   gnt_time[$];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: grants and results are popped as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (search_gnt || lock_gnt) begin
                exp_t e;
                n_gnt++;
                gnt_time.push_back(cyc);
                check("single_gnt", {31'd0, search_gnt & lock_gnt}, 32'd0);
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 32'd1, 32'd0);
                end else begin
                    e = gnt_q.pop_front();
                    check("gnt_ch", {30'd0, (search_gnt ? C_SEARCH : C_LOCK)}, {30'd0, e.ch});
                    check("gnt_dac_code", {24'd0, dac_code}, {24'd0, e.val});
                end
            end
            if (search_pwr_valid || lock_pwr_valid) begin
                exp_t e;
                check("single_valid", {31'd0, search_pwr_valid & lock_pwr_valid}, 32'd0);
                if (val_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = val_q.pop_front();
                    check("valid_ch", {30'd0, (search_pwr_valid ? C_SEARCH : C_LOCK)}, {30'd0, e.ch});
                    check("valid_pwr", {24'd0, pwr_out}, {24'd0, e.val});
                end
            end
        end
    end

    // Answers every pdet_req in its first cycle until the owner is back in INIT.
    task automatic finish_txn(input logic [7:0] pwr);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (arb_state == S_INIT) begin
                done = 1;
                break;
            end
            pdet_ack = pdet_req;
            pdet_pwr = pwr;
            tick();
            pdet_ack = 1'b0;
        end
        if (!done) check("finish_txn_timeout", 32'd1, 32'd0);
    endtask

    vec_t       vecs[4];
    logic [7:0] prev_code;
    int         pdet_cnt;
    bit         ok;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h5A, 8'h00, 1, 8'h33, C_SEARCH, 8'h5A};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h77, 0, 8'h81, C_LOCK,   8'h77};
        vecs[2] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 2, 8'h19, C_SEARCH, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 8'h44, 8'h55, 0, 8'hF0, C_LOCK,   8'h55};

        rst = 1'b1; search_req = 0; lock_req = 0; pdet_ack = 0;
        search_code = 0; lock_code = 0; pdet_pwr = 0;
        #12;
        check("rst_state", {30'd0, arb_state}, {30'd0, S_INIT});
        check("rst_ch_sel", {30'd0, ch_sel}, {30'd0, C_NULL});
        check("rst_dac_code", {24'd0, dac_code}, 32'd0);
        check("rst_pwr_out", {24'd0, pwr_out}, 32'd0);
        check("rst_strobes", {25'd0, search_gnt, lock_gnt, search_pwr_valid, lock_pwr_valid,
                              dac_load, pdet_req, err_timeout}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        prev_code = 8'h00;

        // Single transactions from the table.
        for (int v = 0; v < 4; v++) begin
            search_req = vecs[v].s_req; lock_req = vecs[v].l_req;
            search_code = vecs[v].s_code; lock_code = vecs[v].l_code;
            gnt_q.push_back('{vecs[v].exp_ch, vecs[v].exp_code});
            val_q.push_back('{vecs[v].exp_ch, vecs[v].pwr});
            check("v_dac_hold", {24'd0, dac_code}, {24'd0, prev_code});
            tick();
            check("v_c1_state", {30'd0, arb_state}, {30'd0, S_TUNE});
            check("v_c1_load", {31'd0, dac_load}, 32'd1);
            check("v_c1_ch_sel", {30'd0, ch_sel}, {30'd0, vecs[v].exp_ch});
            search_req = 0; lock_req = 0; search_code = 8'hFF; lock_code = 8'hFF;
            repeat (SETTLE) tick();
            check("v_sync_state", {30'd0, arb_state}, {30'd0, S_SYNC});
            check("v_pdet_req", {31'd0, pdet_req}, 32'd1);
            repeat (vecs[v].ack_dly) tick();
            pdet_ack = 1'b1; pdet_pwr = vecs[v].pwr;
            tick();
            pdet_ack = 1'b0; pdet_pwr = 8'hEE;
            check("v_commit_state", {30'd0, arb_state}, {30'd0, S_COMMIT});
            check("v_commit_pwr", {24'd0, pwr_out}, {24'd0, vecs[v].pwr});
            check("v_commit_pdet", {31'd0, pdet_req}, 32'd0);
            tick();
            check("v_init_state", {30'd0, arb_state}, {30'd0, S_INIT});
            check("v_init_ch_sel", {30'd0, ch_sel}, {30'd0, C_NULL});
            check("v_pwr_hold", {24'd0, pwr_out}, {24'd0, vecs[v].pwr});
            check("v_dac_stable", {24'd0, dac_code}, {24'd0, vecs[v].exp_code});
            prev_code = vecs[v].exp_code;
        end

        // Both held high: strict alternation, one transaction per 3+SETTLE cycles.
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back('{(i % 2 == 0) ? C_SEARCH : C_LOCK, (i % 2 == 0) ? 8'h10 : 8'h20});
            val_q.push_back('{(i % 2 == 0) ? C_SEARCH : C_LOCK, 8'hA1 + 8'(i)});
        end
        gnt_time.delete();
        search_req = 1; lock_req = 1; search_code = 8'h10; lock_code = 8'h20;
        pdet_cnt = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (val_q.size() == 0) begin
                ok = 1;
                break;
            end
            pdet_ack = pdet_req;
            pdet_pwr = 8'hA1 + 8'(pdet_cnt);
            if (pdet_req) pdet_cnt++;
            tick();
            pdet_ack = 1'b0;
        end
        search_req = 0; lock_req = 0;
        check("rr_completed", {31'd0, ok}, 32'd1);
        if (gnt_time.size() >= 2)
            check("rr_throughput", gnt_time[1] - gnt_time[0], 3 + SETTLE);
        else
            check("rr_gnt_count", gnt_time.size(), 4);
        finish_txn(8'h00);

        // Lock-only with no ack: SYNC times out after TIMEOUT cycles.
        gnt_q.push_back('{C_LOCK, 8'h99});
        lock_req = 1; lock_code = 8'h99;
        tick();
        lock_req = 0;
        pdet_cnt = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (pdet_req) pdet_cnt++;
            else if (pdet_cnt > 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("tmo_ended", {31'd0, ok}, 32'd1);
        check("tmo_pdet_cycles", pdet_cnt, TIMEOUT);
        check("tmo_err_pulse", {31'd0, err_timeout}, 32'd1);
        check("tmo_state", {30'd0, arb_state}, {30'd0, S_INIT});
        check("tmo_no_valid", {31'd0, lock_pwr_valid}, 32'd0);
        search_req = 1; lock_req = 1; search_code = 8'h10; lock_code = 8'h20;
        gnt_q.push_back('{C_SEARCH, 8'h10});
        val_q.push_back('{C_SEARCH, 8'h42});
        tick();
        check("tmo_err_once", {31'd0, err_timeout}, 32'd0);
        check("tmo_next_tie", {30'd0, ch_sel}, {30'd0, C_SEARCH});
        search_req = 0; lock_req = 0;
        finish_txn(8'h42);

        // Reset while SYNC is requesting a sample.
        gnt_q.push_back('{C_LOCK, 8'h6B});
        lock_req = 1; lock_code = 8'h6B;
        tick();
        lock_req = 0;
        repeat (SETTLE) tick();
        check("rst_pre_pdet", {31'd0, pdet_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_pdet", {31'd0, pdet_req}, 32'd0);
        check("rst_mid_dac", {24'd0, dac_code}, 32'd0);
        check("rst_mid_ch_sel", {30'd0, ch_sel}, {30'd0, C_NULL});
        check("rst_mid_state", {30'd0, arb_state}, {30'd0, S_INIT});
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_idle", {15'd0, search_gnt, lock_gnt, search_pwr_valid, lock_pwr_valid,
                                    dac_load, pdet_req, err_timeout, pwr_out, dac_code, ch_sel},
                  32'd0);
        end

        // Search drops req after grant; lock raised mid-transaction waits for INIT.
        gnt_q.push_back('{C_SEARCH, 8'h3C});
        val_q.push_back('{C_SEARCH, 8'h5E});
        gnt_q.push_back('{C_LOCK, 8'h4D});
        val_q.push_back('{C_LOCK, 8'h6F});
        search_req = 1; search_code = 8'h3C;
        tick();
        search_req = 0;
        tick();
        lock_req = 1; lock_code = 8'h4D;
        repeat (SETTLE - 1) tick();
        check("drop_sync_owner", {30'd0, ch_sel}, {30'd0, C_SEARCH});
        repeat (3) tick();
        pdet_ack = 1; pdet_pwr = 8'h5E;
        tick();
        pdet_ack = 0;
        check("drop_commit", {31'd0, search_pwr_valid}, 32'd1);
        tick();
        check("drop_init_hold", {30'd0, ch_sel}, {30'd0, C_NULL});
        tick();
        check("drop_lock_gnt", {30'd0, ch_sel}, {30'd0, C_LOCK});
        lock_req = 0;
        finish_txn(8'h6F);

        // pdet_ack noise in INIT and TUNE is ignored.
        pdet_ack = 1; pdet_pwr = 8'hEE;
        tick();
        check("ack_init_state", {30'd0, arb_state}, {30'd0, S_INIT});
        check("ack_init_pwr", {24'd0, pwr_out}, 32'h6F);
        gnt_q.push_back('{C_SEARCH, 8'h11});
        val_q.push_back('{C_SEARCH, 8'h22});
        search_req = 1; search_code = 8'h11;
        tick();
        search_req = 0;
        for (int i = 1; i < SETTLE; i++) begin
            check("ack_tune_state", {30'd0, arb_state}, {30'd0, S_TUNE});
            tick();
        end
        check("ack_tune_last", {30'd0, arb_state}, {30'd0, S_TUNE});
        check("ack_tune_pwr", {24'd0, pwr_out}, 32'h6F);
        tick();
        pdet_ack = 0;
        check("ack_sync_entry", {30'd0, arb_state}, {30'd0, S_SYNC});
        check("ack_sync_pwr", {24'd0, pwr_out}, 32'h6F);
        finish_txn(8'h22);
        tick();

        check("sb_gnt_empty", gnt_q.size(), 0);
        check("sb_valid_empty", val_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
